// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer pipeline: ALU ops, result sources, forward selects.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAlu  = 2'b00,
        ResLoad = 2'b01,
        ResPc4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdMem = 2'b01,
        FwdWb  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Picks the freshest value for one source register: MEM result, then WB result, else held read data.
module forward_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   reg_data_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output fwd_sel_e          sel_o,
    output logic [XLEN-1:0]   data_o
);

    logic rs_nonzero;
    assign rs_nonzero = (rs_i != '0);

    always_comb begin
        sel_o  = FwdReg;
        data_o = reg_data_i;
        if (rs_nonzero && mem_regwrite_i && (mem_rd_i == rs_i)) begin
            sel_o  = FwdMem;
            data_o = mem_data_i;
        end else if (rs_nonzero && wb_regwrite_i && (wb_rd_i == rs_i)) begin
            sel_o  = FwdWb;
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX register: holds one decoded instruction, forwards MEM/WB results into the ALU operands,
// stalls on load-use and drops work on a branch flush.
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IdValid,
    output logic              IdReady,
    input  logic [XLEN-1:0]   IdRD1,
    input  logic [XLEN-1:0]   IdRD2,
    input  logic [XLEN-1:0]   IdImmExt,
    input  logic [REG_AW-1:0] IdRs1,
    input  logic [REG_AW-1:0] IdRs2,
    input  logic [REG_AW-1:0] IdRd,
    input  logic              IdUsesRs2,
    input  logic              IdALUSrc,
    input  logic [2:0]        IdALUControl,
    input  logic              IdRegWrite,
    input  logic [1:0]        IdResultSrc,
    input  logic              Flush,
    input  logic [REG_AW-1:0] MemRd,
    input  logic              MemRegWrite,
    input  logic [XLEN-1:0]   MemALUResult,
    input  logic [REG_AW-1:0] WbRd,
    input  logic              WbRegWrite,
    input  logic [XLEN-1:0]   WbResult,
    output logic              ExValid,
    input  logic              ExReady,
    output logic [2:0]        ALUControl,
    output logic [XLEN-1:0]   SrcA,
    output logic [XLEN-1:0]   SrcB,
    output logic [XLEN-1:0]   ExWriteData,
    output logic [REG_AW-1:0] ExRd,
    output logic              ExRegWrite,
    output logic [1:0]        ExResultSrc
);

    logic              valid_q;
    logic [XLEN-1:0]   rd1_q, rd2_q, imm_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic              alusrc_q, regwrite_q;
    logic [2:0]        aluctl_q;
    logic [1:0]        resultsrc_q;

    fwd_sel_e          fwd_sel_a, fwd_sel_b;
    logic [XLEN-1:0]   fwd_a, fwd_b;
    logic              advance, load_use;

    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .rs_i           (rs1_q),
        .reg_data_i     (rd1_q),
        .mem_rd_i       (MemRd),
        .mem_regwrite_i (MemRegWrite),
        .mem_data_i     (MemALUResult),
        .wb_rd_i        (WbRd),
        .wb_regwrite_i  (WbRegWrite),
        .wb_data_i      (WbResult),
        .sel_o          (fwd_sel_a),
        .data_o         (fwd_a)
    );

    forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .rs_i           (rs2_q),
        .reg_data_i     (rd2_q),
        .mem_rd_i       (MemRd),
        .mem_regwrite_i (MemRegWrite),
        .mem_data_i     (MemALUResult),
        .wb_rd_i        (WbRd),
        .wb_regwrite_i  (WbRegWrite),
        .wb_data_i      (WbResult),
        .sel_o          (fwd_sel_b),
        .data_o         (fwd_b)
    );

    assign advance  = !valid_q || ExReady;
    assign load_use = valid_q && (resultsrc_q == ResLoad) && (rd_q != '0) && IdValid &&
                      ((IdRs1 == rd_q) || (IdUsesRs2 && (IdRs2 == rd_q)));
    assign IdReady  = advance && !load_use && !Flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alusrc_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            aluctl_q    <= '0;
            resultsrc_q <= '0;
        end else if (Flush) begin
            valid_q <= 1'b0;
        end else if (advance && load_use) begin
            valid_q <= 1'b0;
        end else if (advance && IdValid) begin
            valid_q     <= 1'b1;
            rd1_q       <= IdRD1;
            rd2_q       <= IdRD2;
            imm_q       <= IdImmExt;
            rs1_q       <= IdRs1;
            rs2_q       <= IdRs2;
            rd_q        <= IdRd;
            alusrc_q    <= IdALUSrc;
            regwrite_q  <= IdRegWrite;
            aluctl_q    <= IdALUControl;
            resultsrc_q <= IdResultSrc;
        end else if (advance) begin
            valid_q <= 1'b0;
        end else begin
            // Stalled while full: capture producers now, they may retire before we issue.
            if (fwd_sel_a != FwdReg) rd1_q <= fwd_a;
            if (fwd_sel_b != FwdReg) rd2_q <= fwd_b;
        end
    end

    assign ExValid     = valid_q;
    assign ALUControl  = aluctl_q;
    assign SrcA        = fwd_a;
    assign SrcB        = alusrc_q ? imm_q : fwd_b;
    assign ExWriteData = fwd_b;
    assign ExRd        = rd_q;
    assign ExRegWrite  = regwrite_q;
    assign ExResultSrc = resultsrc_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding, load-use bubble, stall refresh, flush, reset.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        IdValid, IdReady;
    logic [31:0] IdRD1, IdRD2, IdImmExt;
    logic [4:0]  IdRs1, IdRs2, IdRd;
    logic        IdUsesRs2, IdALUSrc, IdRegWrite;
    logic [2:0]  IdALUControl;
    logic [1:0]  IdResultSrc;
    logic        Flush;
    logic [4:0]  MemRd, WbRd;
    logic        MemRegWrite, WbRegWrite;
    logic [31:0] MemALUResult, WbResult;
    logic        ExValid, ExReady;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA, SrcB, ExWriteData;
    logic [4:0]  ExRd;
    logic        ExRegWrite;
    logic [1:0]  ExResultSrc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk          (clk),
        .reset        (reset),
        .IdValid      (IdValid),
        .IdReady      (IdReady),
        .IdRD1        (IdRD1),
        .IdRD2        (IdRD2),
        .IdImmExt     (IdImmExt),
        .IdRs1        (IdRs1),
        .IdRs2        (IdRs2),
        .IdRd         (IdRd),
        .IdUsesRs2    (IdUsesRs2),
        .IdALUSrc     (IdALUSrc),
        .IdALUControl (IdALUControl),
        .IdRegWrite   (IdRegWrite),
        .IdResultSrc  (IdResultSrc),
        .Flush        (Flush),
        .MemRd        (MemRd),
        .MemRegWrite  (MemRegWrite),
        .MemALUResult (MemALUResult),
        .WbRd         (WbRd),
        .WbRegWrite   (WbRegWrite),
        .WbResult     (WbResult),
        .ExValid      (ExValid),
        .ExReady      (ExReady),
        .ALUControl   (ALUControl),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .ExWriteData  (ExWriteData),
        .ExRd         (ExRd),
        .ExRegWrite   (ExRegWrite),
        .ExResultSrc  (ExResultSrc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                            input logic uses2, input logic alusrc, input logic [2:0] ctl,
                            input logic [1:0] rsrc);
        IdValid = 1'b1; IdRs1 = rs1; IdRs2 = rs2; IdRd = rd;
        IdRD1 = rd1; IdRD2 = rd2; IdImmExt = imm; IdUsesRs2 = uses2;
        IdALUSrc = alusrc; IdALUControl = ctl; IdRegWrite = 1'b1; IdResultSrc = rsrc;
    endtask

    initial begin
        reset = 1'b1; ExReady = 1'b1; Flush = 1'b0;
        IdValid = 1'b0; IdRD1 = '0; IdRD2 = '0; IdImmExt = '0;
        IdRs1 = '0; IdRs2 = '0; IdRd = '0; IdUsesRs2 = 1'b0; IdALUSrc = 1'b0;
        IdALUControl = '0; IdRegWrite = 1'b0; IdResultSrc = '0;
        MemRd = '0; MemRegWrite = 1'b0; MemALUResult = '0;
        WbRd = '0; WbRegWrite = 1'b0; WbResult = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_valid", {31'b0, ExValid}, 32'd0);
        check("rst_srca", SrcA, 32'd0);
        check("rst_srcb", SrcB, 32'd0);
        check("rst_aluctl", {29'b0, ALUControl}, 32'd0);
        check("rst_rd", {27'b0, ExRd}, 32'd0);
        check("rst_regwrite", {31'b0, ExRegWrite}, 32'd0);
        check("rst_idready", {31'b0, IdReady}, 32'd1);

        // 1: basic accept, one-cycle latency
        id_instr(5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0, 3'b000, 2'b00);
        step();
        check("t1_valid", {31'b0, ExValid}, 32'd1);
        check("t1_srca", SrcA, 32'd5);
        check("t1_srcb", SrcB, 32'd7);
        check("t1_rd", {27'b0, ExRd}, 32'd5);

        // 2: MEM beats WB, WB alone, no forwarding for x0
        id_instr(5'd3, 5'd0, 5'd6, 32'h11, 32'h22, 32'd0, 1'b0, 1'b0, 3'b001, 2'b00);
        step();
        IdValid = 1'b0;
        MemRd = 5'd3; MemRegWrite = 1'b1; MemALUResult = 32'hAA;
        WbRd = 5'd3; WbRegWrite = 1'b1; WbResult = 32'hBB;
        #1 check("t2_mem_wins", SrcA, 32'hAA);
        check("t2_aluctl", {29'b0, ALUControl}, 32'd1);
        MemRegWrite = 1'b0;
        #1 check("t2_wb", SrcA, 32'hBB);
        WbRegWrite = 1'b0;
        #1 check("t2_reg", SrcA, 32'h11);
        id_instr(5'd0, 5'd0, 5'd6, 32'h33, 32'h44, 32'd0, 1'b0, 1'b0, 3'b000, 2'b00);
        step();
        IdValid = 1'b0;
        MemRd = 5'd0; MemRegWrite = 1'b1; WbRd = 5'd0; WbRegWrite = 1'b1;
        #1 check("t2_x0_srca", SrcA, 32'h33);
        check("t2_x0_srcb", SrcB, 32'h44);
        MemRegWrite = 1'b0; WbRegWrite = 1'b0;

        // 3: load-use bubble
        id_instr(5'd1, 5'd0, 5'd4, 32'h100, 32'd0, 32'd8, 1'b0, 1'b1, 3'b000, 2'b01);
        step();
        check("t3_lw_valid", {31'b0, ExValid}, 32'd1);
        check("t3_lw_src", {30'b0, ExResultSrc}, 32'd1);
        check("t3_lw_srcb_imm", SrcB, 32'd8);
        id_instr(5'd1, 5'd4, 5'd6, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 3'b000, 2'b00);
        #1 check("t3_stall_idready", {31'b0, IdReady}, 32'd0);
        step();
        check("t3_bubble", {31'b0, ExValid}, 32'd0);
        check("t3_retry_idready", {31'b0, IdReady}, 32'd1);
        step();
        check("t3_accept", {31'b0, ExValid}, 32'd1);
        check("t3_rd", {27'b0, ExRd}, 32'd6);
        check("t3_srcb", SrcB, 32'd2);

        // 4: stall with a WB producer present for one cycle only
        IdValid = 1'b0; ExReady = 1'b0;
        WbRd = 5'd4; WbRegWrite = 1'b1; WbResult = 32'h55;
        #1 check("t4_c1", SrcB, 32'h55);
        check("t4_idready", {31'b0, IdReady}, 32'd0);
        step();
        WbRegWrite = 1'b0;
        #1 check("t4_c2", SrcB, 32'h55);
        check("t4_valid", {31'b0, ExValid}, 32'd1);
        step();
        check("t4_c3", SrcB, 32'h55);

        // 5: flush while full with an incoming instruction
        id_instr(5'd9, 5'd9, 5'd9, 32'h99, 32'h99, 32'd0, 1'b1, 1'b0, 3'b010, 2'b00);
        Flush = 1'b1; ExReady = 1'b1;
        #1 check("t5_idready", {31'b0, IdReady}, 32'd0);
        step();
        Flush = 1'b0; IdValid = 1'b0;
        check("t5_valid", {31'b0, ExValid}, 32'd0);
        check("t5_rd_kept", {27'b0, ExRd}, 32'd6);
        check("t5_srca_kept", SrcA, 32'd1);

        // 6: immediate on SrcB while store data still forwards from MEM
        id_instr(5'd0, 5'd7, 5'd8, 32'd0, 32'h77, 32'hFFFF_FFFC, 1'b1, 1'b1, 3'b000, 2'b00);
        step();
        IdValid = 1'b0;
        MemRd = 5'd7; MemRegWrite = 1'b1; MemALUResult = 32'h1234;
        #1 check("t6_srcb_imm", SrcB, 32'hFFFF_FFFC);
        check("t6_wdata_fwd", ExWriteData, 32'h1234);

        // reset during a stall empties the stage
        ExReady = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1 check("rst_stall_valid", {31'b0, ExValid}, 32'd0);
        check("rst_stall_rd", {27'b0, ExRd}, 32'd0);
        check("rst_stall_srcb", SrcB, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
